sram_port_arbiter: RTL and testbench
====================================

Name: sram_port_arbiter

Overview:
- Shares the single synchronous SRAM port between two requesters.
- The write requester is the camera-side input FIFO drain. The read requester is the display-side address/readback path.
- Uses burst-quota round-robin with urgency override and an anti-starvation limit.
- Inserts one idle bus-turnaround cycle whenever ownership moves from read to write. The downstream SRAM sequencer drives the port only while holding a grant.

Parameters:
- WR_BURST, 4: maximum consecutive write grant cycles while a read is pending.
- RD_BURST, 4: maximum consecutive read grant cycles while a write is pending.
- STARVE_LIMIT, 16: wait cycles after which a pending requester forces a switch.
- CNT_W, 5: width of the burst and starvation counters. Must hold max(WR_BURST, RD_BURST, STARVE_LIMIT).

Ports:
- CLK  in  1  system clock; also the SRAM clock.
- RESET_N  in  1  asynchronous active-low reset.
- iWR_REQ  in  1  write requester has data (input FIFO holds at least 4 words).
- iWR_URGENT  in  1  input FIFO near full.
- iRD_REQ  in  1  read requester has a translated address ready and the display FIFO has space.
- iRD_URGENT  in  1  display FIFO near empty.
- oWR_GNT  out  1  write owns the port this cycle.
- oRD_GNT  out  1  read owns the port this cycle.
- oOWNER  out  2  bus state: 00 idle, 01 write, 10 read, 11 turnaround.
- oSTARVE  out  1  a forced switch is being taken this cycle.
- oBURST_CNT  out  CNT_W  grant cycles used in the current burst.

Behaviour:
- Reset is asynchronous, active-low, on CLK rising edge otherwise. Reset values:
  - state = IDLE, oWR_GNT = 0, oRD_GNT = 0, oOWNER = 00, oSTARVE = 0, oBURST_CNT = 0.
  - Last owner LAST = RD, so the first contested grant goes to write.
  - Both wait counters = 0.
- Moore outputs: grants decode from the state register only. There is no combinational path from requests to grants.
- Latency: a request asserted in cycle N gives a grant in cycle N+1 at the earliest (IDLE to WR/RD).
- A transfer occurs when req && gnt. A requester may drop req while granted. The grant persists for that one cycle and the sequencer must qualify transfers with req.
- States:
  - IDLE: no grant.
  - WR: oWR_GNT = 1.
  - RD: oRD_GNT = 1.
  - TURN: no grant, oOWNER = 11, exactly one cycle.
- Selection (used from IDLE, and when leaving WR or RD), in priority order:
  1. A starved requester (wait count = STARVE_LIMIT).
  2. The sole urgent requester.
  3. Round-robin: the requester not equal to LAST.
  4. The sole requester.
- From IDLE: select per the rule above.
  - WR is entered directly, with no TURN, because the bus is already idle.
  - No requests: stay in IDLE.
- WR, each cycle:
  - Increment BURST_CNT, saturating at 2^CNT_W - 1.
  - Leave when any of the following holds:
    - !iWR_REQ;
    - iRD_REQ && BURST_CNT + 1 >= WR_BURST && !iWR_URGENT;
    - iRD_URGENT && !iWR_URGENT;
    - RD wait count = STARVE_LIMIT (overrides iWR_URGENT).
  - On leaving: go to RD if iRD_REQ, else IDLE. BURST_CNT is cleared and LAST is set to WR.
- RD: symmetric to WR, with these differences:
  - Leaving to serve a write goes to TURN, not WR.
  - Leaving with no write pending goes to IDLE.
  - LAST is set to RD.
- TURN: always goes to WR on the next cycle, even if iWR_REQ has dropped; the resulting WR cycle then exits to IDLE per the WR rules. A read request arriving during TURN does not preempt.
- Burst quota with no contention: when the other side is not requesting, BURST_CNT still counts but the quota is ignored. The current owner keeps the port indefinitely.
- Wait counters:
  - WR_WAIT increments each cycle iWR_REQ && !oWR_GNT, saturating at STARVE_LIMIT.
  - WR_WAIT clears on the cycle oWR_GNT = 1 or when iWR_REQ = 0.
  - RD_WAIT behaves symmetrically.
- oSTARVE = 1 for the single cycle in which a state transition is taken because of a saturated wait counter.
- Both urgent: round-robin with quota applies. Urgency cannot pre-empt an urgent owner.
- Simultaneous first requests from IDLE with LAST = RD: grant goes to write.
- Invariant: oWR_GNT and oRD_GNT are never both 1. Illegal state encodings return to IDLE on the next cycle with no grant.
- Reset mid-burst: grants drop asynchronously and the arbiter restarts from IDLE with LAST = RD.

Test Plan:
- Reset release, iWR_REQ = iRD_REQ = 1 from cycle 0 with defaults:
  - Required: WR granted in cycles 1–4, TURN never appears on WR to RD, RD in cycles 5–8, TURN in cycle 9, WR from cycle 10.
  - The pattern repeats with period 9.
- Only iRD_REQ held for 40 cycles: RD granted continuously from cycle 1, oBURST_CNT saturates at 31, no TURN, oSTARVE = 0.
- WR owning, iRD_URGENT asserted in cycle 2 of the burst with iWR_URGENT = 0: RD granted on the next cycle, so the WR burst length is 2.
- Both urgent, RD owning with WR_BURST = RD_BURST = 30, STARVE_LIMIT = 16: WR_WAIT reaches 16, then oSTARVE pulses for 1 cycle, then TURN, then WR grant.
- RD owning, iWR_REQ pulses high for 1 cycle only at the quota boundary: TURN, then WR is granted for 1 cycle with iWR_REQ = 0 (no transfer), then IDLE.
- Assert RESET_N = 0 mid-WR burst: both grants 0 immediately (asynchronous). After release with both requests high, WR is granted first in cycle 1.

Source files
------------

// File: rtl/sram_port_arbiter.sv
// rtl/sram_port_arbiter.sv - two-requester SRAM port arbiter
//
// Shares one synchronous SRAM port between the camera-side write drain and
// the display-side read path. Burst-quota round-robin with urgency override
// and an anti-starvation limit. One idle turnaround cycle is inserted
// whenever ownership moves from read to write.
//
// Ports:
//   CLK         system / SRAM clock
//   RESET_N     asynchronous active-low reset
//   iWR_REQ     write requester has data
//   iWR_URGENT  input FIFO near full
//   iRD_REQ     read requester has an address ready and display FIFO space
//   iRD_URGENT  display FIFO near empty
//   oWR_GNT     write owns the port this cycle
//   oRD_GNT     read owns the port this cycle
//   oOWNER      00 idle, 01 write, 10 read, 11 turnaround
//   oSTARVE     a starvation-forced transition is taken this cycle
//   oBURST_CNT  grant cycles used in the current burst

module sram_port_arbiter #(
    parameter int WR_BURST     = 4,
    parameter int RD_BURST     = 4,
    parameter int STARVE_LIMIT = 16,
    parameter int CNT_W        = 5
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic             iWR_REQ,
    input  logic             iWR_URGENT,
    input  logic             iRD_REQ,
    input  logic             iRD_URGENT,
    output logic             oWR_GNT,
    output logic             oRD_GNT,
    output logic [1:0]       oOWNER,
    output logic             oSTARVE,
    output logic [CNT_W-1:0] oBURST_CNT
);

    // State encoding doubles as the oOWNER bus code.
    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_WR   = 2'b01;
    localparam logic [1:0] ST_RD   = 2'b10;
    localparam logic [1:0] ST_TURN = 2'b11;

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] STARVE_C = CNT_W'(STARVE_LIMIT);
    localparam logic [CNT_W:0]   WR_Q     = (CNT_W+1)'(WR_BURST);
    localparam logic [CNT_W:0]   RD_Q     = (CNT_W+1)'(RD_BURST);

    logic [1:0]       state_q, state_d;
    logic             last_wr_q, last_wr_d;
    logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;
    logic [CNT_W-1:0] wr_wait_q, wr_wait_d;
    logic [CNT_W-1:0] rd_wait_q, rd_wait_d;
    logic             starve;

    logic             in_wr, in_rd;
    logic [CNT_W:0]   burst_next_w;
    logic [CNT_W-1:0] burst_sat;
    logic             wr_at_limit, rd_at_limit;
    logic             wr_starved, rd_starved;
    logic             wr_leave, rd_leave;
    logic             pick_wr, sel_starve;

    assign in_wr = (state_q == ST_WR);
    assign in_rd = (state_q == ST_RD);

    // One extra bit so the quota compare cannot wrap.
    assign burst_next_w = {1'b0, burst_cnt_q} + {{CNT_W{1'b0}}, 1'b1};
    assign burst_sat    = (burst_cnt_q == CNT_MAX) ? CNT_MAX : burst_next_w[CNT_W-1:0];

    assign wr_at_limit = (wr_wait_q == STARVE_C);
    assign rd_at_limit = (rd_wait_q == STARVE_C);
    assign wr_starved  = iWR_REQ && wr_at_limit;
    assign rd_starved  = iRD_REQ && rd_at_limit;

    // Quota only binds when the owner is not urgent, or both sides are
    // urgent; an urgent owner can only be displaced by starvation.
    assign wr_leave = !iWR_REQ
                   || (iRD_REQ && (burst_next_w >= WR_Q) && (!iWR_URGENT || iRD_URGENT))
                   || (iRD_URGENT && !iWR_URGENT)
                   || rd_at_limit;

    assign rd_leave = !iRD_REQ
                   || (iWR_REQ && (burst_next_w >= RD_Q) && (!iRD_URGENT || iWR_URGENT))
                   || (iWR_URGENT && !iRD_URGENT)
                   || wr_at_limit;

    // Selection from IDLE: starved, sole urgent, round-robin, sole requester.
    always_comb begin
        pick_wr    = iWR_REQ;
        sel_starve = 1'b0;
        if (wr_starved != rd_starved) begin
            pick_wr    = wr_starved;
            sel_starve = 1'b1;
        end else if (wr_starved) begin
            pick_wr    = !last_wr_q;
            sel_starve = 1'b1;
        end else if (iWR_REQ && iRD_REQ && (iWR_URGENT != iRD_URGENT)) begin
            pick_wr = iWR_URGENT;
        end else if (iWR_REQ && iRD_REQ) begin
            pick_wr = !last_wr_q;
        end
    end

    always_comb begin
        state_d     = state_q;
        last_wr_d   = last_wr_q;
        burst_cnt_d = burst_cnt_q;
        starve      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                burst_cnt_d = '0;
                if (iWR_REQ || iRD_REQ) begin
                    state_d = pick_wr ? ST_WR : ST_RD;
                    starve  = sel_starve;
                end
            end
            ST_WR: begin
                if (wr_leave) begin
                    state_d     = iRD_REQ ? ST_RD : ST_IDLE;
                    burst_cnt_d = '0;
                    last_wr_d   = 1'b1;
                    starve      = rd_at_limit;
                end else begin
                    burst_cnt_d = burst_sat;
                end
            end
            ST_RD: begin
                if (rd_leave) begin
                    // Read-to-write handover always passes through TURN.
                    state_d     = iWR_REQ ? ST_TURN : ST_IDLE;
                    burst_cnt_d = '0;
                    last_wr_d   = 1'b0;
                    starve      = wr_at_limit;
                end else begin
                    burst_cnt_d = burst_sat;
                end
            end
            ST_TURN: begin
                state_d     = ST_WR;
                burst_cnt_d = '0;
            end
            default: begin
                state_d     = ST_IDLE;
                burst_cnt_d = '0;
            end
        endcase
    end

    // Wait counters saturate at the limit and clear when granted or idle.
    always_comb begin
        wr_wait_d = '0;
        rd_wait_d = '0;
        if (iWR_REQ && !in_wr) begin
            wr_wait_d = wr_at_limit ? STARVE_C : wr_wait_q + CNT_ONE;
        end
        if (iRD_REQ && !in_rd) begin
            rd_wait_d = rd_at_limit ? STARVE_C : rd_wait_q + CNT_ONE;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q     <= ST_IDLE;
            last_wr_q   <= 1'b0;
            burst_cnt_q <= '0;
            wr_wait_q   <= '0;
            rd_wait_q   <= '0;
        end else begin
            state_q     <= state_d;
            last_wr_q   <= last_wr_d;
            burst_cnt_q <= burst_cnt_d;
            wr_wait_q   <= wr_wait_d;
            rd_wait_q   <= rd_wait_d;
        end
    end

    assign oWR_GNT    = in_wr;
    assign oRD_GNT    = in_rd;
    assign oOWNER     = state_q;
    assign oSTARVE    = starve;
    assign oBURST_CNT = burst_cnt_q;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb/tb_sram_port_arbiter.sv - self-checking bench for sram_port_arbiter

module tb_sram_port_arbiter;

    localparam int WRB  = 4;
    localparam int RDB  = 4;
    localparam int SL   = 16;
    localparam int CMAX = 31;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wr_req = 1'b0, wr_urg = 1'b0, rd_req = 1'b0, rd_urg = 1'b0;
    logic       wg, rg, st, wg_b, rg_b, st_b;
    logic [1:0] own, own_b;
    logic [4:0] bc, bc_b;

    always #5 clk = ~clk;

    sram_port_arbiter dut (
        .CLK(clk), .RESET_N(rst_n),
        .iWR_REQ(wr_req), .iWR_URGENT(wr_urg), .iRD_REQ(rd_req), .iRD_URGENT(rd_urg),
        .oWR_GNT(wg), .oRD_GNT(rg), .oOWNER(own), .oSTARVE(st), .oBURST_CNT(bc)
    );

    sram_port_arbiter #(.WR_BURST(30), .RD_BURST(30), .STARVE_LIMIT(16), .CNT_W(5)) dut_b (
        .CLK(clk), .RESET_N(rst_n),
        .iWR_REQ(wr_req), .iWR_URGENT(wr_urg), .iRD_REQ(rd_req), .iRD_URGENT(rd_urg),
        .oWR_GNT(wg_b), .oRD_GNT(rg_b), .oOWNER(own_b), .oSTARVE(st_b), .oBURST_CNT(bc_b)
    );

    int total = 0;
    int bad = 0;

    typedef struct {
        int         seq;
        logic       wr, wu, rd, ru;
        logic       ewg, erg;
        logic [1:0] eown;
        logic       est;
        int         ebc;
    } vec_t;

    vec_t tbl[$];

    // Reference model: owner code 0 idle, 1 write, 2 read, 3 turnaround.
    int m_own, m_bc, m_ww, m_rw;
    bit m_last_wr;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            if (bad <= 40) $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    task automatic m_reset();
        m_own = 0; m_bc = 0; m_ww = 0; m_rw = 0; m_last_wr = 1'b0;
    endtask

    task automatic m_step(input bit wr, input bit wu, input bit rd, input bit ru, output bit stv);
        int nxt, quota, ot_wait, ww_n, rw_n;
        bit wr_st, rd_st, me_wr, my_req, my_urg, ot_req, ot_urg, go;
        wr_st = wr && (m_ww == SL);
        rd_st = rd && (m_rw == SL);
        ww_n  = (wr && m_own != 1) ? ((m_ww < SL) ? m_ww + 1 : SL) : 0;
        rw_n  = (rd && m_own != 2) ? ((m_rw < SL) ? m_rw + 1 : SL) : 0;
        stv   = 1'b0;
        nxt   = m_own;
        if (m_own == 0) begin
            if (wr_st || rd_st) begin
                stv = 1'b1;
                nxt = (wr_st && rd_st) ? (m_last_wr ? 2 : 1) : (wr_st ? 1 : 2);
            end else if (wr && rd) begin
                if (wu && !ru)      nxt = 1;
                else if (ru && !wu) nxt = 2;
                else                nxt = m_last_wr ? 2 : 1;
            end else if (wr) nxt = 1;
            else if (rd)     nxt = 2;
        end else if (m_own == 3) begin
            nxt = 1;
        end else begin
            me_wr   = (m_own == 1);
            my_req  = me_wr ? wr : rd;
            my_urg  = me_wr ? wu : ru;
            ot_req  = me_wr ? rd : wr;
            ot_urg  = me_wr ? ru : wu;
            quota   = me_wr ? WRB : RDB;
            ot_wait = me_wr ? m_rw : m_ww;
            go = !my_req
              || (ot_req && (m_bc + 1 >= quota) && !(my_urg && !ot_urg))
              || (ot_urg && !my_urg)
              || (ot_wait == SL);
            if (go) begin
                stv       = (ot_wait == SL);
                m_last_wr = me_wr;
                m_bc      = 0;
                nxt       = !ot_req ? 0 : (me_wr ? 2 : 3);
            end else begin
                m_bc = (m_bc < CMAX) ? m_bc + 1 : CMAX;
            end
        end
        m_own = nxt;
        m_ww  = ww_n;
        m_rw  = rw_n;
    endtask

    function automatic vec_t mk(input int seq, input logic [3:0] in, input logic ewg, input logic erg,
                                input logic [1:0] eown, input logic est, input int ebc);
        vec_t v;
        v.seq = seq;
        {v.wr, v.wu, v.rd, v.ru} = in;
        v.ewg = ewg; v.erg = erg; v.eown = eown; v.est = est; v.ebc = ebc;
        return v;
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        wr_req = 1'b0; wr_urg = 1'b0; rd_req = 1'b0; rd_urg = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        m_reset();
    endtask

    task automatic apply(input vec_t v, input int idx);
        wr_req = v.wr; wr_urg = v.wu; rd_req = v.rd; rd_urg = v.ru;
        #1;
        chk($sformatf("s%0d_c%0d_wr_gnt", v.seq, idx), int'(wg), int'(v.ewg));
        chk($sformatf("s%0d_c%0d_rd_gnt", v.seq, idx), int'(rg), int'(v.erg));
        chk($sformatf("s%0d_c%0d_owner", v.seq, idx), int'(own), int'(v.eown));
        chk($sformatf("s%0d_c%0d_starve", v.seq, idx), int'(st), int'(v.est));
        chk($sformatf("s%0d_c%0d_burst", v.seq, idx), int'(bc), v.ebc);
        @(negedge clk);
    endtask

    // Reset asserted in cycle 'at' of a contested run; grants must fall at
    // once and the restart must favour write.
    task automatic reset_mid(input int at);
        do_reset();
        wr_req = 1'b1; rd_req = 1'b1;
        for (int c = 0; c < at; c++) @(negedge clk);
        #1;
        chk($sformatf("rmid%0d_pre_owner", at), int'(own), (((at - 1) % 9) < 4) ? 1 : 2);
        #2 rst_n = 1'b0;
        #1;
        chk($sformatf("rmid%0d_async_wr_gnt", at), int'(wg), 0);
        chk($sformatf("rmid%0d_async_rd_gnt", at), int'(rg), 0);
        chk($sformatf("rmid%0d_async_owner", at), int'(own), 0);
        @(negedge clk);
        rst_n = 1'b1;
        m_reset();
        #1;
        chk($sformatf("rmid%0d_c0_owner", at), int'(own), 0);
        @(negedge clk);
        #1;
        chk($sformatf("rmid%0d_c1_wr_gnt", at), int'(wg), 1);
        chk($sformatf("rmid%0d_c1_rd_gnt", at), int'(rg), 0);
        @(negedge clk);
    endtask

    initial begin
        int p, cyc;
        int e_own, e_bc;
        bit e_st;

        // Seq 1: both requesting from cycle 0, period-9 pattern.
        tbl.push_back(mk(1, 4'b1010, 0, 0, 2'd0, 0, 0));
        for (int c = 1; c <= 27; c++) begin
            p = (c - 1) % 9;
            if (p < 4)      tbl.push_back(mk(1, 4'b1010, 1, 0, 2'd1, 0, p));
            else if (p < 8) tbl.push_back(mk(1, 4'b1010, 0, 1, 2'd2, 0, p - 4));
            else            tbl.push_back(mk(1, 4'b1010, 0, 0, 2'd3, 0, 0));
        end
        // Seq 2: read alone for 40 cycles, burst counter saturates.
        tbl.push_back(mk(2, 4'b0010, 0, 0, 2'd0, 0, 0));
        for (int c = 1; c <= 40; c++)
            tbl.push_back(mk(2, 4'b0010, 0, 1, 2'd2, 0, (c - 1 < CMAX) ? c - 1 : CMAX));
        // Seq 3: urgent read cuts a write burst to two cycles.
        tbl.push_back(mk(3, 4'b1000, 0, 0, 2'd0, 0, 0));
        tbl.push_back(mk(3, 4'b1000, 1, 0, 2'd1, 0, 0));
        tbl.push_back(mk(3, 4'b1011, 1, 0, 2'd1, 0, 1));
        tbl.push_back(mk(3, 4'b1011, 0, 1, 2'd2, 0, 0));
        tbl.push_back(mk(3, 4'b0000, 0, 1, 2'd2, 0, 1));
        tbl.push_back(mk(3, 4'b0000, 0, 0, 2'd0, 0, 0));
        // Seq 4: one-cycle write pulse at the read quota boundary.
        tbl.push_back(mk(4, 4'b0010, 0, 0, 2'd0, 0, 0));
        tbl.push_back(mk(4, 4'b0010, 0, 1, 2'd2, 0, 0));
        tbl.push_back(mk(4, 4'b0010, 0, 1, 2'd2, 0, 1));
        tbl.push_back(mk(4, 4'b0010, 0, 1, 2'd2, 0, 2));
        tbl.push_back(mk(4, 4'b1010, 0, 1, 2'd2, 0, 3));
        tbl.push_back(mk(4, 4'b0000, 0, 0, 2'd3, 0, 0));
        tbl.push_back(mk(4, 4'b0000, 1, 0, 2'd1, 0, 0));
        tbl.push_back(mk(4, 4'b0000, 0, 0, 2'd0, 0, 0));

        // Outputs held at zero while reset is asserted, regardless of requests.
        wr_req = 1'b1; rd_req = 1'b1;
        @(negedge clk);
        #1;
        chk("in_reset_wr_gnt", int'(wg), 0);
        chk("in_reset_rd_gnt", int'(rg), 0);
        chk("in_reset_owner", int'(own), 0);
        chk("in_reset_starve", int'(st), 0);
        chk("in_reset_burst", int'(bc), 0);

        cyc = 0;
        for (int i = 0; i < tbl.size(); i++) begin
            if (i == 0 || tbl[i].seq != tbl[i-1].seq) begin
                do_reset();
                cyc = 0;
            end
            apply(tbl[i], cyc);
            cyc++;
        end

        // Both urgent, read owning, long quotas: write starves out the read.
        do_reset();
        for (int c = 0; c <= 21; c++) begin
            wr_req = (c >= 2); wr_urg = (c >= 2); rd_req = 1'b1; rd_urg = 1'b1;
            #1;
            e_own = (c == 0) ? 0 : (c <= 18) ? 2 : (c == 19) ? 3 : 1;
            chk($sformatf("both_urg_c%0d_owner", c), int'(own_b), e_own);
            chk($sformatf("both_urg_c%0d_starve", c), int'(st_b), (c == 18) ? 1 : 0);
            @(negedge clk);
        end

        reset_mid(2);
        reset_mid(6);

        // Randomised run against the reference model.
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 7) == 0)  wr_req = ~wr_req;
            if ($urandom_range(0, 7) == 0)  rd_req = ~rd_req;
            if ($urandom_range(0, 11) == 0) wr_urg = ~wr_urg;
            if ($urandom_range(0, 11) == 0) rd_urg = ~rd_urg;
            #1;
            e_own = m_own;
            e_bc  = m_bc;
            m_step(wr_req, wr_urg, rd_req, rd_urg, e_st);
            chk($sformatf("rnd_c%0d_owner", c), int'(own), e_own);
            chk($sformatf("rnd_c%0d_wr_gnt", c), int'(wg), (e_own == 1) ? 1 : 0);
            chk($sformatf("rnd_c%0d_rd_gnt", c), int'(rg), (e_own == 2) ? 1 : 0);
            chk($sformatf("rnd_c%0d_starve", c), int'(st), int'(e_st));
            chk($sformatf("rnd_c%0d_burst", c), int'(bc), e_bc);
            chk($sformatf("rnd_c%0d_excl", c), int'(wg & rg), 0);
            @(negedge clk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
